// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multicycle RV32I control path: FSM states,
// opcodes, mux selects, ALU controls, and a per-state control-word helper.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE,
    EXECUTER, EXECUTEI, ALUWB, JAL, BEQ, FAULT
  } state_t;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  // Moore control word; pc_update/branch are combined with zero at the top.
  typedef struct packed {
    logic       adr_src;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic       pc_update;
    logic       branch;
    logic       illegal;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
  } ctl_t;

  function automatic ctl_t ctl_of(input state_t s);
    ctl_t c;
    c = '0;
    case (s)
      FETCH:    begin c.ir_write = 1'b1; c.pc_update = 1'b1;
                      c.alu_src_b = SRCB_FOUR; c.result_src = RES_ALURESULT; end
      DECODE:   begin c.alu_src_a = SRCA_OLDPC; c.alu_src_b = SRCB_IMM; end
      MEMADR:   begin c.alu_src_a = SRCA_RS1; c.alu_src_b = SRCB_IMM; end
      MEMREAD:  c.adr_src = 1'b1;
      MEMWB:    begin c.result_src = RES_DATA; c.reg_write = 1'b1; end
      MEMWRITE: begin c.adr_src = 1'b1; c.mem_write = 1'b1; end
      EXECUTER: begin c.alu_src_a = SRCA_RS1; c.alu_src_b = SRCB_RS2;
                      c.alu_op = ALUOP_FUNCT; end
      EXECUTEI: begin c.alu_src_a = SRCA_RS1; c.alu_src_b = SRCB_IMM;
                      c.alu_op = ALUOP_FUNCT; end
      ALUWB:    c.reg_write = 1'b1;
      JAL:      begin c.alu_src_a = SRCA_OLDPC; c.alu_src_b = SRCB_FOUR;
                      c.pc_update = 1'b1; end
      BEQ:      begin c.alu_src_a = SRCA_RS1; c.alu_op = ALUOP_SUB;
                      c.branch = 1'b1; end
      FAULT:    c.illegal = 1'b1;
      default:  ;
    endcase
    return c;
  endfunction

  function automatic logic [1:0] imm_of(input logic [6:0] op);
    case (op)
      OP_SW:   return IMM_S;
      OP_BEQ:  return IMM_B;
      OP_JAL:  return IMM_J;
      default: return IMM_I;
    endcase
  endfunction

endpackage

// File: rtl/mc_controller_alu_decoder.sv
// ALU decoder: maps alu_op plus instruction fields to an ALU operation.
module alu_decoder
  import mc_ctrl_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [2:0] funct3,
  input  logic       op5,
  input  logic       funct7b5,
  output logic [2:0] alu_control
);

  // Only R-type (op5=1) with funct7b5 turns funct3=000 into a subtract.
  always_comb begin
    alu_control = ALU_ADD;
    case (alu_op)
      ALUOP_SUB:   alu_control = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3)
          3'b000:  alu_control = (op5 & funct7b5) ? ALU_SUB : ALU_ADD;
          3'b010:  alu_control = ALU_SLT;
          3'b110:  alu_control = ALU_OR;
          3'b111:  alu_control = ALU_AND;
          default: alu_control = ALU_ADD;
        endcase
      end
      default:     alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mc_controller.sv
// Main control FSM of the multicycle RV32I core.
// Optional feature macro: MC_CTRL_MEM_WAIT_EN adds mem_ready and stalls
// FETCH / MEMREAD / MEMWRITE until memory completes.
module mc_controller
  import mc_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
`ifdef MC_CTRL_MEM_WAIT_EN
  input  logic       mem_ready,
`endif
  output logic       pc_write,
  output logic       adr_src,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] imm_src,
  output logic [2:0] alu_control,
  output logic       illegal
);

  state_t     state, nxt;
  ctl_t       ctl_q;
  logic       rdy, strobe_ok;
  logic [2:0] alu_dec;

`ifdef MC_CTRL_MEM_WAIT_EN
  assign rdy = mem_ready;
`else
  assign rdy = 1'b1;
`endif

  // Next-state selection; memory states hold until the access completes.
  always_comb begin
    nxt = state;
    case (state)
      FETCH:    nxt = rdy ? DECODE : FETCH;
      DECODE: begin
        case (opcode)
          OP_LW, OP_SW: nxt = MEMADR;
          OP_R:         nxt = EXECUTER;
          OP_I:         nxt = EXECUTEI;
          OP_JAL:       nxt = JAL;
          OP_BEQ:       nxt = BEQ;
          default:      nxt = FAULT;
        endcase
      end
      MEMADR:   nxt = opcode[5] ? MEMWRITE : MEMREAD;
      MEMREAD:  nxt = rdy ? MEMWB : MEMREAD;
      MEMWB:    nxt = FETCH;
      MEMWRITE: nxt = rdy ? FETCH : MEMWRITE;
      EXECUTER: nxt = ALUWB;
      EXECUTEI: nxt = ALUWB;
      ALUWB:    nxt = FETCH;
      JAL:      nxt = ALUWB;
      BEQ:      nxt = FETCH;
      FAULT:    nxt = FAULT;
      default:  nxt = FAULT;
    endcase
  end

  // State plus registered control word for the state being entered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= FETCH;
      ctl_q <= ctl_of(FETCH);
    end else begin
      state <= nxt;
      ctl_q <= ctl_of(nxt);
    end
  end

  alu_decoder u_alu_dec (
    .alu_op      (ctl_q.alu_op),
    .funct3      (funct3),
    .op5         (opcode[5]),
    .funct7b5    (funct7b5),
    .alu_control (alu_dec)
  );

  // Side-effect strobes in FETCH/MEMWRITE fire only on the completing cycle.
  assign strobe_ok = rdy | ~((state == FETCH) | (state == MEMWRITE));

  // Output drive; everything is held at zero while reset is high.
  always_comb begin
    pc_write    = 1'b0;
    adr_src     = 1'b0;
    mem_write   = 1'b0;
    ir_write    = 1'b0;
    reg_write   = 1'b0;
    result_src  = 2'b00;
    alu_src_a   = 2'b00;
    alu_src_b   = 2'b00;
    imm_src     = 2'b00;
    alu_control = 3'b000;
    illegal     = 1'b0;
    if (!reset) begin
      pc_write    = (ctl_q.pc_update & strobe_ok) | (ctl_q.branch & zero);
      adr_src     = ctl_q.adr_src;
      mem_write   = ctl_q.mem_write & strobe_ok;
      ir_write    = ctl_q.ir_write & strobe_ok;
      reg_write   = ctl_q.reg_write;
      result_src  = ctl_q.result_src;
      alu_src_a   = ctl_q.alu_src_a;
      alu_src_b   = ctl_q.alu_src_b;
      imm_src     = imm_of(opcode);
      alu_control = alu_dec;
      illegal     = ctl_q.illegal;
    end
  end

endmodule

// File: tb/tb_mc_controller.sv
// Randomized scoreboard bench for mc_controller: per-cycle expected outputs
// come from a per-instruction-class phase list and are compared on negedge.
module tb_mc_controller;

  logic       clk = 1'b1;
  logic       reset;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7b5, zero;
  logic       pc_write, adr_src, mem_write, ir_write, reg_write, illegal;
  logic [1:0] result_src, alu_src_a, alu_src_b, imm_src;
  logic [2:0] alu_control;
`ifdef MC_CTRL_MEM_WAIT_EN
  logic       mem_ready;
  localparam bit WAIT_EN = 1'b1;
`else
  localparam bit WAIT_EN = 1'b0;
`endif

  always #5 clk = ~clk;

  mc_controller dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct3(funct3),
    .funct7b5(funct7b5), .zero(zero),
`ifdef MC_CTRL_MEM_WAIT_EN
    .mem_ready(mem_ready),
`endif
    .pc_write(pc_write), .adr_src(adr_src), .mem_write(mem_write),
    .ir_write(ir_write), .reg_write(reg_write), .result_src(result_src),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .imm_src(imm_src),
    .alu_control(alu_control), .illegal(illegal)
  );

  typedef struct packed {
    logic       illegal, pc_write, adr_src, mem_write, ir_write, reg_write;
    logic [1:0] result_src, a, b, imm;
    logic [2:0] alu;
  } obs_t;

  // Instruction phases, one per cycle of the textbook multicycle sequence.
  localparam int P_F = 0, P_D = 1, P_MA = 2, P_MR = 3, P_MWB = 4, P_MWR = 5,
                 P_EXR = 6, P_EXI = 7, P_AWB = 8, P_J = 9, P_B = 10, P_FLT = 11;

  obs_t  exp_q[$];
  string tag_q[$];
  int    n_tests = 0, n_fail = 0;

  function automatic logic [1:0] imm_ref(input logic [6:0] op);
    if (op == 7'b0100011) return 2'b01;
    if (op == 7'b1100011) return 2'b10;
    if (op == 7'b1101111) return 2'b11;
    return 2'b00;
  endfunction

  // Arithmetic op requested by an R/I instruction.
  function automatic logic [2:0] funct_ref(input logic [6:0] op, input logic [2:0] f3,
                                           input logic f7);
    case (f3)
      3'b000:  return (op == 7'b0110011 && f7) ? 3'b001 : 3'b000;
      3'b010:  return 3'b101;
      3'b110:  return 3'b011;
      3'b111:  return 3'b010;
      default: return 3'b000;
    endcase
  endfunction

  function automatic obs_t ref_out(input int ph, input logic [6:0] op, input logic [2:0] f3,
                                   input logic f7, input logic z, input logic rdy);
    obs_t e;
    e = '0;
    e.imm = imm_ref(op);
    case (ph)
      P_F:   begin e.ir_write = rdy; e.pc_write = rdy; e.b = 2'b10; e.result_src = 2'b10; end
      P_D:   begin e.a = 2'b01; e.b = 2'b01; end
      P_MA:  begin e.a = 2'b10; e.b = 2'b01; end
      P_MR:  e.adr_src = 1'b1;
      P_MWB: begin e.result_src = 2'b01; e.reg_write = 1'b1; end
      P_MWR: begin e.adr_src = 1'b1; e.mem_write = rdy; end
      P_EXR: begin e.a = 2'b10; e.b = 2'b00; e.alu = funct_ref(op, f3, f7); end
      P_EXI: begin e.a = 2'b10; e.b = 2'b01; e.alu = funct_ref(op, f3, f7); end
      P_AWB: e.reg_write = 1'b1;
      P_J:   begin e.a = 2'b01; e.b = 2'b10; e.pc_write = 1'b1; end
      P_B:   begin e.a = 2'b10; e.alu = 3'b001; e.pc_write = z; end
      P_FLT: e.illegal = 1'b1;
      default: ;
    endcase
    return e;
  endfunction

  // Monitor: one expected word per cycle, compared away from the active edge.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      obs_t e, a;
      string t;
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      a = '{illegal, pc_write, adr_src, mem_write, ir_write, reg_write,
            result_src, alu_src_a, alu_src_b, imm_src, alu_control};
      n_tests++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL %s: got %h want %h (ill,pcw,adr,mw,irw,rw,res,a,b,imm,alu)", t, a, e);
      end
    end
  end

  task automatic step(input int ph, input logic [6:0] op, input logic [2:0] f3,
                      input logic f7, input int zf, input logic rdy, input string tag);
    logic z;
    z = (zf < 0) ? ($urandom_range(0, 1) == 1) : zf[0];
    reset = 1'b0; opcode = op; funct3 = f3; funct7b5 = f7; zero = z;
`ifdef MC_CTRL_MEM_WAIT_EN
    mem_ready = rdy;
`endif
    exp_q.push_back(ref_out(ph, op, f3, f7, z, rdy));
    tag_q.push_back(tag);
    @(posedge clk); #1;
  endtask

  task automatic reset_cycle(input string tag);
    reset = 1'b1;
    opcode = 7'($urandom); funct3 = 3'($urandom); funct7b5 = 1'($urandom); zero = 1'($urandom);
`ifdef MC_CTRL_MEM_WAIT_EN
    mem_ready = 1'($urandom);
`endif
    exp_q.push_back('0);
    tag_q.push_back(tag);
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic phase(input int ph, input logic [6:0] op, input logic [2:0] f3,
                       input logic f7, input int zf, input int nwait, input string tag);
    int n;
    n = (nwait < 0) ? int'($urandom_range(0, 3)) : nwait;
    if (!WAIT_EN || !(ph == P_F || ph == P_MR || ph == P_MWR)) n = 0;
    repeat (n) step(ph, op, f3, f7, zf, 1'b0, {tag, "_wait"});
    step(ph, op, f3, f7, zf, 1'b1, tag);
  endtask

  // Runs one instruction; abort_at = phase index replaced by a reset cycle,
  // -1 none, -2 random small chance at each phase.
  task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                           input int zf, input int abort_at, input int fwait, input string tag);
    int phs[$];
    phs = '{P_F, P_D};
    case (op)
      7'b0000011: phs = {phs, P_MA, P_MR, P_MWB};
      7'b0100011: phs = {phs, P_MA, P_MWR};
      7'b0110011: phs = {phs, P_EXR, P_AWB};
      7'b0010011: phs = {phs, P_EXI, P_AWB};
      7'b1101111: phs = {phs, P_J, P_AWB};
      7'b1100011: phs = {phs, P_B};
      default:    for (int k = 0; k < 10; k++) phs.push_back(P_FLT);
    endcase
    foreach (phs[i]) begin
      if (i == abort_at || (abort_at == -2 && $urandom_range(0, 39) == 0)) begin
        reset_cycle({tag, "_rst_mid"});
        return;
      end
      phase(phs[i], op, f3, f7, zf, (i == 0) ? fwait : -1, tag);
    end
    if (phs[phs.size()-1] == P_FLT) reset_cycle({tag, "_rst_fault"});
  endtask

  initial begin
    logic [6:0] ops[7];
    logic [6:0] op;
    int         guard;
    ops = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011,
            7'b1101111, 7'b1100011, 7'b0000000};
    reset = 1'b1; opcode = '0; funct3 = '0; funct7b5 = 1'b0; zero = 1'b0;
`ifdef MC_CTRL_MEM_WAIT_EN
    mem_ready = 1'b1;
`endif
    reset_cycle("reset0");
    reset_cycle("reset1");
    // lw abandoned by reset in its MEMADR cycle, then a clean lw
    run_instr(7'b0000011, 3'b010, 1'b0, -1, 2, -1, "lw_abort");
    run_instr(7'b0000011, 3'b010, 1'b0, -1, -1, -1, "lw");
    run_instr(7'b0100011, 3'b010, 1'b0, -1, -1, -1, "sw");
    run_instr(7'b0110011, 3'b000, 1'b1, -1, -1, -1, "r_sub");
    run_instr(7'b0010011, 3'b000, 1'b1, -1, -1, -1, "i_addi");
    run_instr(7'b1100011, 3'b000, 1'b0, 1, -1, -1, "beq_taken");
    run_instr(7'b1100011, 3'b000, 1'b0, 0, -1, -1, "beq_not");
    run_instr(7'b1101111, 3'b000, 1'b0, -1, -1, -1, "jal");
    run_instr(7'b0000000, 3'b000, 1'b0, -1, -1, -1, "fault");
    run_instr(7'b0110011, 3'b111, 1'b0, -1, -1, 3, "fetch_wait3");
    // randomized mix, including illegal opcodes and stray resets
    for (int n = 0; n < 300; n++) begin
      op = ops[$urandom_range(0, 6)];
      if (op == 7'b0000000) op = 7'($urandom);
      run_instr(op, 3'($urandom), 1'($urandom), -1, -2, -1, "rand");
    end
    guard = 0;
    while (exp_q.size() > 0 && guard < 20) begin
      @(posedge clk); guard++;
    end
    if (exp_q.size() > 0) begin
      n_tests++; n_fail++;
      $display("FAIL drain: %0d expected words left, want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
